ifu_fetch_buf: RTL and testbench

Instruction fetch buffer between the fetch/redirect logic and the cache subsystem's `ifu_*` port. It prefetches sequential 64-bit aligned words from the I-cache path, holding at most one request outstanding. It buffers the words in a small FIFO and hands 32-bit instructions with their PC to decode over a valid/ready handshake. On a redirect it flushes all buffered and in-flight data.

---
 rtl/ifu_fetch_buf_pkg.sv | 31 +++
 rtl/ifu_fetch_buf_fetch_fifo.sv | 73 +++++++
 rtl/ifu_fetch_buf.sv | 163 ++++++++++++++++
 tb/tb_ifu_fetch_buf.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_buf_pkg
// Purpose  : Shared types and constants for the instruction fetch buffer.
//            Holds the fetch word width, the default reset PC, the request
//            FSM state encoding and the FIFO entry layout.
// Revision : 1.0 - initial release
// ============================================================================
package ifu_fetch_buf_pkg;

  // Cache returns one aligned 64-bit word per request
  localparam int unsigned FETCH_WORD_W = 64;
  // Word address tag: PC bits [31:3]
  localparam int unsigned FETCH_TAG_W  = 29;
  // Default fetch PC after reset
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

  // One buffered word together with the word-aligned address it came from
  typedef struct packed {
    logic [FETCH_TAG_W-1:0]  tag;
    logic [FETCH_WORD_W-1:0] word;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/ifu_fetch_buf_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : DEPTH-entry synchronous FIFO of fetched words with their tags.
//            Registered storage; head is visible the cycle after a push.
//            Clear has priority over push and pop. DEPTH is a power of two.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import ifu_fetch_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             w_push;
  logic             w_pop;

  // With a power-of-two depth the count MSB alone marks "full"
  assign full_o  = count_q[PTR_W];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i && !empty_o;

  // Storage write; contents need no reset since empty gates every use
  always_ff @(posedge clk) begin
    if (w_push && !clear_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers wrap naturally modulo DEPTH; simultaneous push+pop keeps count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ifu_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_buf
// Purpose  : Instruction fetch buffer. Prefetches sequential 64-bit words
//            with one request outstanding, buffers them in fetch_fifo and
//            hands 32-bit instructions plus PC to decode. A flush redirects
//            the fetch PC and drops buffered and in-flight data.
//            Optional: define IFU_FETCH_PERF_EN to add the stall_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch_buf
  import ifu_fetch_buf_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        flush_valid,
  input  logic [31:0] flush_pc,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  output logic [31:0] ifu_addr_req,
  input  logic [63:0] ifu_data_rsp,
  input  logic        ifu_rsp_valid,
  output logic        ifu_rsp_ready,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef IFU_FETCH_PERF_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e           state_q;
  logic [FETCH_TAG_W-1:0] pc_q;       // next word address to request
  logic [FETCH_TAG_W-1:0] addr_q;     // address of the current/last request
  logic                   discard_q;  // in-flight response belongs to old path
  logic                   sel_q;      // which half of the head word is next

  logic [FETCH_TAG_W-1:0] w_flush_tag;
  logic                   w_push;
  logic                   w_hs;
  logic                   w_pop;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [CNT_W-1:0]       w_fifo_count;
  fetch_entry_t           w_push_entry;
  fetch_entry_t           w_head;
  logic                   w_unused;

  assign w_flush_tag = flush_pc[31:3];

  // A response is kept only if it belongs to the current path
  assign w_push = (state_q == ST_WAIT) && ifu_rsp_valid && !discard_q && !flush_valid;
  assign w_hs   = instr_valid && instr_ready;
  assign w_pop  = w_hs && sel_q;

  assign w_push_entry.tag  = addr_q;
  assign w_push_entry.word = ifu_data_rsp;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (CLK),
    .rst_n       (RSTn),
    .clear_i     (flush_valid),
    .push_i      (w_push),
    .push_data_i (w_push_entry),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .count_o     (w_fifo_count),
    .full_o      (w_fifo_full),
    .empty_o     (w_fifo_empty)
  );

  // Request FSM: at most one outstanding fetch; a flush retargets the PC and
  // marks any request already committed to the cache for discard
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC[31:3];
      addr_q    <= RESET_PC[31:3];
      discard_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (flush_valid) begin
            addr_q  <= w_flush_tag;
            pc_q    <= w_flush_tag + 29'd1;
            state_q <= ST_REQ;
          end else if (!w_fifo_full) begin
            addr_q  <= pc_q;
            pc_q    <= pc_q + 29'd1;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          // The valid request cannot be withdrawn, so its address is kept
          if (flush_valid) begin
            pc_q      <= w_flush_tag;
            discard_q <= 1'b1;
          end
          if (ifu_req_ready) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (flush_valid) pc_q <= w_flush_tag;
          if (ifu_rsp_valid) begin
            state_q   <= ST_IDLE;
            discard_q <= 1'b0;
          end else if (flush_valid) begin
            discard_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Half-select: low half first, pop the entry after the high half
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sel_q <= RESET_PC[2];
    end else if (flush_valid) begin
      sel_q <= flush_pc[2];
    end else if (w_hs) begin
      sel_q <= ~sel_q;
    end
  end

  assign ifu_req_valid = (state_q == ST_REQ);
  assign ifu_addr_req  = {addr_q, 3'b000};
  assign ifu_rsp_ready = 1'b1;

  // With nothing buffered the instruction outputs show their idle values
  assign instr_valid = !w_fifo_empty;
  assign instr       = w_fifo_empty ? 32'h0 :
                       (sel_q ? w_head.word[63:32] : w_head.word[31:0]);
  assign instr_pc    = w_fifo_empty ? RESET_PC : {w_head.tag, sel_q, 2'b00};

  assign w_unused = ^{flush_pc[1:0], w_fifo_count};

`ifdef IFU_FETCH_PERF_EN
  logic [31:0] stall_cnt_q;

  // Count cycles where decode is ready but starved, saturating at all-ones
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      stall_cnt_q <= 32'h0;
    end else if (instr_ready && !instr_valid && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_fetch_buf
// Purpose  : Self-checking bench for ifu_fetch_buf. A cache responder
//            returns address-derived words; a stream model predicts the
//            instruction/PC sequence from reset and flush targets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch_buf;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        flush_valid;
  logic [31:0] flush_pc;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr_req;
  logic [63:0] ifu_data_rsp;
  logic        ifu_rsp_valid;
  logic        ifu_rsp_ready;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef IFU_FETCH_PERF_EN
  logic [31:0] stall_cnt;
`endif

  ifu_fetch_buf #(
    .DEPTH    (4),
    .RESET_PC (RST_PC)
  ) dut (
    .CLK           (CLK),
    .RSTn          (RSTn),
    .flush_valid   (flush_valid),
    .flush_pc      (flush_pc),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr_req  (ifu_addr_req),
    .ifu_data_rsp  (ifu_data_rsp),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_ready (ifu_rsp_ready),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc)
`ifdef IFU_FETCH_PERF_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int          total = 0;
  int          bad   = 0;
  int          acc_cnt = 0;
  int          hs_cnt  = 0;
  int          rdy_mode = 0;   // 0: ready always, 1: random, 2: never
  int          lat_fix  = 2;   // 0: random latency 1..4
  logic [31:0] acc_log [$];
  logic [31:0] hs_log  [$];
  logic [31:0] exp_q   [$];

  // Memory image: instruction at byte address a
  function automatic logic [31:0] fw(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h3C5A_96E1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_acc(input string nm, input int idx, input logic [31:0] exp);
    if (idx < acc_log.size()) chk(nm, acc_log[idx], exp);
    else begin
      total++; bad++;
      $display("FAIL %s: no request #%0d seen, want %h", nm, idx, exp);
    end
  endtask

  task automatic check_hs(input string nm, input int idx, input logic [31:0] exp);
    if (idx < hs_log.size()) chk(nm, hs_log[idx], exp);
    else begin
      total++; bad++;
      $display("FAIL %s: no instruction #%0d seen, want pc %h", nm, idx, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_acc(input int n, input string nm);
    for (int i = 0; i < 100 && acc_cnt <= n; i++) cyc();
    if (acc_cnt <= n) begin
      total++; bad++;
      $display("FAIL %s: timeout waiting for request, got %0d want >%0d", nm, acc_cnt, n);
    end
  endtask

  // Cache responder: accepts per rdy_mode, answers lat cycles after accept
  initial begin : responder
    logic [31:0] pa;
    int          cnt;
    bit          pend;
    pend = 1'b0; cnt = 0; pa = '0;
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_data_rsp  = '0;
    forever begin
      @(posedge CLK);
      #1;
      ifu_rsp_valid = 1'b0;
      if (!RSTn) begin
        pend = 1'b0;
        ifu_req_ready = 1'b0;
      end else begin
        if (pend) begin
          if (cnt == 0) begin
            ifu_rsp_valid = 1'b1;
            ifu_data_rsp  = {fw(pa + 32'd4), fw(pa)};
            pend = 1'b0;
          end else cnt--;
        end
        case (rdy_mode)
          0:       ifu_req_ready = 1'b1;
          1:       ifu_req_ready = ($urandom_range(0, 1) == 1);
          default: ifu_req_ready = 1'b0;
        endcase
        if (ifu_req_valid && ifu_req_ready && !pend) begin
          pa   = ifu_addr_req;
          pend = 1'b1;
          cnt  = ((lat_fix != 0) ? lat_fix : int'($urandom_range(1, 4))) - 1;
          acc_log.push_back(pa);
          acc_cnt++;
          chk("req_align", {29'h0, pa[2:0]}, 32'h0);
        end
      end
    end
  end

  // Monitor/scoreboard: instruction stream from the latest reset/flush target
  initial begin : monitor
    logic [31:0] nxt_pc;
    logic [31:0] e;
    bit          flush_d;
    nxt_pc = RST_PC; flush_d = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RSTn) begin
        exp_q.delete();
        nxt_pc  = RST_PC;
        flush_d = 1'b0;
      end else begin
        if (flush_d) chk("valid_after_flush", 32'(instr_valid), 32'd0);
        if (instr_valid && instr_ready) begin
          if (exp_q.size() == 0) begin
            exp_q.push_back(nxt_pc);
            nxt_pc = nxt_pc + 32'd4;
          end
          e = exp_q.pop_front();
          chk("instr_pc", instr_pc, e);
          chk("instr_data", instr, fw(e));
          hs_log.push_back(instr_pc);
          hs_cnt++;
        end
        if (flush_valid) begin
          exp_q.delete();
          nxt_pc = {flush_pc[31:2], 2'b00};
        end
        flush_d = flush_valid;
      end
    end
  end

  initial begin : stim
    logic [31:0] old;
    int a0, a1, h1;
    RSTn = 1'b0; flush_valid = 1'b0; flush_pc = '0; instr_ready = 1'b0;
    repeat (3) cyc();
    chk("rst_req_valid", 32'(ifu_req_valid), 32'd0);
    chk("rst_addr", ifu_addr_req, RST_PC);
    chk("rst_rsp_ready", 32'(ifu_rsp_ready), 32'd1);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, RST_PC);

    // Reset release: request in the first cycle, sequential stream
    RSTn = 1'b1;
    chk("pre_req_valid", 32'(ifu_req_valid), 32'd0);
    cyc();
    chk("first_req_valid", 32'(ifu_req_valid), 32'd1);
    chk("first_req_addr", ifu_addr_req, RST_PC);
    instr_ready = 1'b1;
    repeat (40) cyc();
    check_acc("acc0", 0, RST_PC);
    check_acc("acc1", 1, RST_PC + 32'd8);
    check_hs("hs0", 0, RST_PC);
    check_hs("hs1", 1, RST_PC + 32'd4);

    // Mid-run reset, then backpressure: exactly DEPTH words fetched
    instr_ready = 1'b0;
    RSTn = 1'b0;
    cyc(); cyc();
    chk("midrst_instr_valid", 32'(instr_valid), 32'd0);
    chk("midrst_req_valid", 32'(ifu_req_valid), 32'd0);
    RSTn = 1'b1;
    a0 = acc_cnt;
    repeat (60) cyc();
    chk("bp_requests", 32'(acc_cnt - a0), 32'd4);
    chk("bp_req_valid", 32'(ifu_req_valid), 32'd0);
    chk("bp_instr_valid", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    repeat (40) cyc();

    // Flush while a response is in flight
    lat_fix = 4;
    a0 = acc_cnt;
    wait_acc(a0, "wait_acc");
    cyc();
    flush_valid = 1'b1; flush_pc = 32'h8000_0104;
    a1 = acc_cnt;
    cyc();
    flush_valid = 1'b0;
    h1 = hs_cnt;
    wait_acc(a1, "wait_next");
    check_acc("wait_flush_addr", a1, 32'h8000_0100);
    repeat (20) cyc();
    check_hs("wait_flush_pc", h1, 32'h8000_0104);

    // Flush while a request is stalled by the cache
    lat_fix = 2;
    rdy_mode = 2;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (ifu_req_valid && !ifu_req_ready) break;
    end
    chk("req_stalled", 32'(ifu_req_valid && !ifu_req_ready), 32'd1);
    old = ifu_addr_req;
    a1 = acc_cnt;
    flush_valid = 1'b1; flush_pc = 32'h8000_0208;
    for (int i = 0; i < 3; i++) begin
      cyc();
      flush_valid = 1'b0;
      chk("req_hold_addr", ifu_addr_req, old);
      chk("req_hold_valid", 32'(ifu_req_valid), 32'd1);
    end
    rdy_mode = 0;
    h1 = hs_cnt;
    wait_acc(a1, "req_old");
    check_acc("req_old_addr", a1, old);
    wait_acc(a1 + 1, "req_new");
    check_acc("req_new_addr", a1 + 1, 32'h8000_0208);
    repeat (20) cyc();
    check_hs("req_flush_pc", h1, 32'h8000_0208);

    // Flush in the same cycle as the response
    lat_fix = 2;
    a0 = acc_cnt;
    wait_acc(a0, "rsp_acc");
    cyc(); cyc();
    flush_valid = 1'b1; flush_pc = 32'h8000_0314;
    a1 = acc_cnt;
    cyc();
    flush_valid = 1'b0;
    h1 = hs_cnt;
    wait_acc(a1, "rsp_next");
    check_acc("rsp_flush_addr", a1, 32'h8000_0310);
    repeat (20) cyc();
    check_hs("rsp_flush_pc", h1, 32'h8000_0314);

    // Randomized traffic, decode stalls and flushes
    rdy_mode = 1;
    lat_fix  = 0;
    for (int i = 0; i < 800; i++) begin
      cyc();
      instr_ready = ($urandom_range(0, 3) != 0);
      if (flush_valid) flush_valid = 1'b0;
      else if ($urandom_range(0, 29) == 0) begin
        flush_valid = 1'b1;
        flush_pc    = 32'h8000_0000 | 32'($urandom_range(0, 4095));
      end
    end
    flush_valid = 1'b0;
    instr_ready = 1'b1;
    h1 = hs_cnt;
    repeat (40) cyc();
    chk("drain_progress", 32'(hs_cnt > h1), 32'd1);

`ifdef IFU_FETCH_PERF_EN
    // Starved decode cycles: cache never accepts, decode ready 10 cycles
    rdy_mode = 2;
    instr_ready = 1'b0;
    RSTn = 1'b0;
    cyc(); cyc();
    chk("stall_rst", stall_cnt, 32'd0);
    RSTn = 1'b1;
    repeat (3) cyc();
    instr_ready = 1'b1;
    repeat (10) cyc();
    instr_ready = 1'b0;
    cyc();
    chk("stall_cnt", stall_cnt, 32'd10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
